pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shifter supporting logical left, logical right, arithmetic right and rotate right in one datapath. It sits between the register-read stage and writeback as a multi-cycle shift unit. It has one registered mux level per shift-amount bit and a valid/ready handshake on both sides. A tag travels with each operation so the issuing logic can match results to destinations.

## Interface
Parameters:
- WIDTH, 32: data width; power of two, ≥ 4.
- TAG_W, 5: width of the passthrough tag (destination register index).
- SW, log2(WIDTH): derived localparam; shift-amount width and pipeline depth. Not overridable.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SW  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.
- out_zero  output  1  out_data == 0.

## Operation
- Pipeline stage k (k = 0..SW-1) handles shamt bit SW-1-k, MSB first, i.e. shift by 2^(SW-1-k).
- Each stage is a conditional shift by its amount, followed by a register.
- Each stage register holds: valid, data, remaining shamt bits, op, tag.
- Fill rules, per mode:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the original in_data[WIDTH-1] enter at the MSB. The sign bit is captured at issue and carried in the op field, not re-read from partial results.
  - ROR: bits leaving the LSB enter at the MSB.
- shamt = 0 passes data unchanged in every mode.
- No saturation is needed: shamt cannot exceed WIDTH-1.
- Global advance signal: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor. Stage 0 loads from the input with valid = in_valid.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- in_ready = adv, combinationally.
  - An operation is accepted exactly on a cycle with in_valid && in_ready.
- The last stage register drives out_valid, out_data and out_tag directly.
  - out_zero is a combinational reduction of the registered out_data.
- Data, tag and op registers of invalid stages may update freely. Only the valid bits are architecturally significant, but see the reset rule below.
- There is no internal state machine beyond the valid shift chain. Throughput is one operation per cycle while out_ready is held high.

## Timing
- Latency: an operation accepted in cycle t appears with out_valid = 1 in cycle t+SW if adv stayed 1. Each cycle of adv = 0 adds one cycle.
- With WIDTH = 32, latency is 5 cycles.
- Reset, synchronous, takes effect at the clock edge where reset = 1:
  - all stage valid bits clear to 0;
  - out_data = 0, out_tag = 0, hence out_zero = 1;
  - out_valid = 0, hence in_ready = 1 during and after reset.
- Reset mid-operation discards every in-flight operation. No result emerges for them.
- Input presented in the same cycle as reset is dropped.
- Stall behaviour while out_valid && !out_ready:
  - outputs hold stable;
  - in_ready = 0;
  - the upstream must keep in_valid and its payload stable until accepted.
- Simultaneous pop and push (out_valid, out_ready, in_valid all 1): the result leaves, every stage shifts, and the new operation enters stage 0 in the same edge.
- out_ready is ignored when out_valid = 0.
- Outputs never change on a cycle where out_valid = 1 and out_ready = 0.

## Test plan
- Reset, then idle: hold reset 2 cycles, then release.
  - Required: out_valid = 0, out_data = 0, out_zero = 1, in_ready = 1.
- Mode sweep, WIDTH = 32, in_data = 0x8000_00F1, shamt = 4, tags 1–4, back-to-back with out_ready = 1.
  - SLL → 0x0000_0F10.
  - SRL → 0x0800_000F.
  - SRA → 0xF800_000F.
  - ROR → 0x1800_000F.
  - Results arrive on cycles t+5 through t+8 with tags 1–4 in order.
- Boundaries:
  - SRA 0x8000_0000 by 31 → 0xFFFF_FFFF.
  - SRL 0x8000_0000 by 31 → 0x0000_0001.
  - SLL 0x0000_0001 by 31 → 0x8000_0000.
  - Any mode with shamt 0 returns the input.
  - SLL 0x0000_0002 by 31 → 0 with out_zero = 1.
- Backpressure: stream 8 operations while out_ready toggles 1,0,0,1,… .
  - No result is lost or duplicated; order is preserved.
  - Outputs stay stable during stalls.
  - in_ready == (!out_valid || out_ready) every cycle.
- Reset mid-flight: issue 3 operations, assert reset 2 cycles after the first.
  - Required: no out_valid ever seen for those 3.
  - A new operation after reset emerges exactly 5 cycles after acceptance.
- Parameter check at WIDTH = 8, TAG_W = 3: ROR 0x81 by 1 → 0xC0 with latency 3; SRA 0x90 by 2 → 0xE4.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR with one registered mux
// level per shift-amount bit (MSB first), valid/ready on both sides and a
// passthrough tag so the issuer can route each result to its destination.
module pipelined_shifter #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One conditional shift level. op = {issue-time sign, mode}; the sign is
  // the fill for SRA so partial results are never re-inspected for it.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int unsigned      n
  );
    logic signed [WIDTH:0] ext;
    logic [WIDTH-1:0]      r;
    ext = {op[2], d};
    if (n == 0) begin
      r = d;
    end else begin
      unique case (op[1:0])
        OP_SLL:  r = d << n;
        OP_SRL:  r = d >> n;
        OP_SRA:  r = WIDTH'(ext >>> n);
        default: r = (d >> n) | (d << (WIDTH - n));
      endcase
    end
    return r;
  endfunction

  // Stage-output buses; index k is the register at the end of stage k.
  logic             vld_p   [SW];
  logic [WIDTH-1:0] data_p  [SW];
  logic [SW-1:0]    shamt_p [SW];
  logic [2:0]       op_p    [SW];
  logic [TAG_W-1:0] tag_p   [SW];

  // Whole pipe advances together; it only freezes when the result is stuck.
  logic adv;
  assign adv      = !vld_p[SW-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int unsigned AMT  = 1 << (SW - 1 - k);
    localparam bit          LAST = (k == SW - 1);

    logic             vld_i;
    logic [WIDTH-1:0] data_i;
    logic [SW-1:0]    shamt_i;
    logic [2:0]       op_i;
    logic [TAG_W-1:0] tag_i;

    logic             vld_r;
    logic [WIDTH-1:0] data_r;
    logic [SW-1:0]    shamt_r;
    logic [2:0]       op_r;
    logic [TAG_W-1:0] tag_r;

    if (k == 0) begin : g_head
      assign vld_i   = in_valid;
      assign data_i  = in_data;
      assign shamt_i = in_shamt;
      assign op_i    = {in_data[WIDTH-1], in_op};
      assign tag_i   = in_tag;
    end else begin : g_body
      assign vld_i   = vld_p[k-1];
      assign data_i  = data_p[k-1];
      assign shamt_i = shamt_p[k-1];
      assign op_i    = op_p[k-1];
      assign tag_i   = tag_p[k-1];
    end

    // ---- stage k boundary: valid chain, cleared by reset ----
    always_ff @(posedge clock) begin
      if (reset) vld_r <= 1'b0;
      else if (adv) vld_r <= vld_i;
    end

    // Shifted data and tag; the output stage is also cleared so out_zero reads 1.
    always_ff @(posedge clock) begin
      if (LAST && reset) begin
        data_r <= '0;
        tag_r  <= '0;
      end else if (adv) begin
        data_r <= shift_step(data_i, op_i, shamt_i[SW-1-k] ? AMT : 0);
        tag_r  <= tag_i;
      end
    end

    // Remaining shift amount and mode travel alongside the data.
    always_ff @(posedge clock) begin
      if (adv) begin
        shamt_r <= shamt_i;
        op_r    <= op_i;
      end
    end

    assign vld_p[k]   = vld_r;
    assign data_p[k]  = data_r;
    assign shamt_p[k] = shamt_r;
    assign op_p[k]    = op_r;
    assign tag_p[k]   = tag_r;
  end

  assign out_valid = vld_p[SW-1];
  assign out_data  = data_p[SW-1];
  assign out_tag   = tag_p[SW-1];
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH=32 and WIDTH=8.
`timescale 1ns/1ps
module tb_pipelined_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv32, ir32, ov32, or32, oz32;
  logic [31:0] id32, od32;
  logic [4:0]  is32, it32, ot32;
  logic [1:0]  io32;

  logic       iv8, ir8, ov8, or8, oz8;
  logic [7:0] id8, od8;
  logic [2:0] is8, it8, ot8;
  logic [1:0] io8;

  pipelined_shifter #(.WIDTH(32), .TAG_W(5)) u32 (
    .clock(clk), .reset(rst),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_shamt(is32),
    .in_op(io32), .in_tag(it32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_tag(ot32),
    .out_zero(oz32)
  );

  pipelined_shifter #(.WIDTH(8), .TAG_W(3)) u8 (
    .clock(clk), .reset(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_shamt(is8),
    .in_op(io8), .in_tag(it8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_tag(ot8),
    .out_zero(oz8)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  tag;
    logic        z;
    int          acc;
    int          lat;
    bit          chk;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer readiness: 1 normally, 1,0,0 repeating under backpressure.
  initial begin
    int i;
    i = 0;
    or32 = 1'b1;
    or8  = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (bp_en) begin
        or32 = ((i % 3) == 0);
        i++;
      end else begin
        or32 = 1'b1;
      end
    end
  end

  // Monitor for the 32-bit unit.
  initial begin
    exp_t        e;
    bit          hold;
    logic [31:0] hd;
    logic [4:0]  ht;
    hold = 1'b0;
    hd = '0;
    ht = '0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (bp_en) check("in_ready_rule", 32'(ir32), 32'(!ov32 || or32));
      if (hold) begin
        check("stall_valid", 32'(ov32), 32'd1);
        check("stall_data", od32, hd);
        check("stall_tag", 32'(ot32), 32'(ht));
      end
      hold = ov32 && !or32;
      hd   = od32;
      ht   = ot32;
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out32: got data 0x%08h tag %0d, required no result", od32, ot32);
        end else begin
          e = q32.pop_front();
          check("data32", od32, e.d);
          check("tag32", 32'(ot32), 32'(e.tag));
          check("zero32", 32'(oz32), 32'(e.z));
          if (e.chk) check("latency32", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Monitor for the 8-bit unit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && ov8 && or8) begin
        if (q8.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out8: got data 0x%02h, required no result", od8);
        end else begin
          e = q8.pop_front();
          check("data8", 32'(od8), e.d);
          check("tag8", 32'(ot8), 32'(e.tag));
          check("zero8", 32'(oz8), 32'(e.z));
          if (e.chk) check("latency8", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic issue32(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                         input logic [4:0] tag, input logic [31:0] ex, input bit chk, input bit track);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk); #1;
    iv32 = 1'b1; id32 = d; is32 = sh; io32 = op; it32 = tag;
    forever begin
      #1;
      if (ir32) begin
        if (track) begin
          e.d = ex; e.tag = 8'(tag); e.z = (ex == 32'd0);
          e.acc = cyc; e.lat = 5; e.chk = chk;
          q32.push_back(e);
        end
        break;
      end
      w++;
      if (w > 100) begin
        tests++;
        fails++;
        $display("FAIL issue32_timeout: in_ready stayed 0, required 1 within 100 cycles");
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic issue8(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op,
                        input logic [2:0] tag, input logic [7:0] ex);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk); #1;
    iv8 = 1'b1; id8 = d; is8 = sh; io8 = op; it8 = tag;
    forever begin
      #1;
      if (ir8) begin
        e.d = 32'(ex); e.tag = 8'(tag); e.z = (ex == 8'd0);
        e.acc = cyc; e.lat = 3; e.chk = 1'b1;
        q8.push_back(e);
        break;
      end
      w++;
      if (w > 100) begin
        tests++;
        fails++;
        $display("FAIL issue8_timeout: in_ready stayed 0, required 1 within 100 cycles");
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic idle_all();
    @(negedge clk); #1;
    iv32 = 1'b0;
    iv8  = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check(name, 32'(q32.size() + q8.size()), 32'd0);
  endtask

  typedef struct { logic [31:0] d; logic [4:0] sh; logic [1:0] op; logic [31:0] ex; } vec_t;

  initial begin
    vec_t bp[8];
    bp[0] = '{32'h0000_0001, 5'd1,  2'b00, 32'h0000_0002};
    bp[1] = '{32'h8000_0000, 5'd3,  2'b01, 32'h1000_0000};
    bp[2] = '{32'h8000_0000, 5'd3,  2'b10, 32'hF000_0000};
    bp[3] = '{32'h0000_0003, 5'd1,  2'b11, 32'h8000_0001};
    bp[4] = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800};
    bp[5] = '{32'h1234_5678, 5'd16, 2'b01, 32'h0000_1234};
    bp[6] = '{32'h7FFF_FFFF, 5'd30, 2'b10, 32'h0000_0001};
    bp[7] = '{32'h1234_5678, 5'd4,  2'b11, 32'h8123_4567};

    rst = 1'b1;
    iv32 = 1'b0; id32 = '0; is32 = '0; io32 = '0; it32 = '0;
    iv8  = 1'b0; id8  = '0; is8  = '0; io8  = '0; it8  = '0;

    // Reset for two edges, then idle state.
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    check("rst_out_valid32", 32'(ov32), 32'd0);
    check("rst_out_data32", od32, 32'd0);
    check("rst_out_zero32", 32'(oz32), 32'd1);
    check("rst_in_ready32", 32'(ir32), 32'd1);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_out_zero8", 32'(oz8), 32'd1);

    // Mode sweep, back to back.
    issue32(32'h8000_00F1, 5'd4, 2'b00, 5'd1, 32'h0000_0F10, 1'b1, 1'b1);
    issue32(32'h8000_00F1, 5'd4, 2'b01, 5'd2, 32'h0800_000F, 1'b1, 1'b1);
    issue32(32'h8000_00F1, 5'd4, 2'b10, 5'd3, 32'hF800_000F, 1'b1, 1'b1);
    issue32(32'h8000_00F1, 5'd4, 2'b11, 5'd4, 32'h1800_000F, 1'b1, 1'b1);
    idle_all();
    drain("drain_sweep");

    // Boundaries.
    issue32(32'h8000_0000, 5'd31, 2'b10, 5'd5,  32'hFFFF_FFFF, 1'b1, 1'b1);
    issue32(32'h8000_0000, 5'd31, 2'b01, 5'd6,  32'h0000_0001, 1'b1, 1'b1);
    issue32(32'h0000_0001, 5'd31, 2'b00, 5'd7,  32'h8000_0000, 1'b1, 1'b1);
    issue32(32'h0000_0002, 5'd31, 2'b00, 5'd8,  32'h0000_0000, 1'b1, 1'b1);
    issue32(32'hDEAD_BEEF, 5'd0,  2'b00, 5'd9,  32'hDEAD_BEEF, 1'b1, 1'b1);
    issue32(32'hDEAD_BEEF, 5'd0,  2'b01, 5'd10, 32'hDEAD_BEEF, 1'b1, 1'b1);
    issue32(32'hDEAD_BEEF, 5'd0,  2'b10, 5'd11, 32'hDEAD_BEEF, 1'b1, 1'b1);
    issue32(32'hDEAD_BEEF, 5'd0,  2'b11, 5'd12, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle_all();
    drain("drain_bound");

    // Backpressure stream.
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++)
      issue32(bp[i].d, bp[i].sh, bp[i].op, 5'(16 + i), bp[i].ex, 1'b0, 1'b1);
    idle_all();
    drain("drain_bp");
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-flight: three untracked operations, reset two cycles after the first.
    issue32(32'h0000_00FF, 5'd1, 2'b00, 5'd25, 32'h0, 1'b0, 1'b0);
    issue32(32'h0000_00FF, 5'd2, 2'b00, 5'd26, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    id32 = 32'h0000_00FF; is32 = 5'd3; io32 = 2'b00; it32 = 5'd27;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    iv32 = 1'b0;
    #1;
    check("midrst_out_zero32", 32'(oz32), 32'd1);
    check("midrst_in_ready32", 32'(ir32), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      check("midrst_no_valid32", 32'(ov32), 32'd0);
    end
    issue32(32'h0000_00F0, 5'd4, 2'b01, 5'd30, 32'h0000_000F, 1'b1, 1'b1);
    idle_all();
    drain("drain_midrst");

    // Narrow instance.
    issue8(8'h81, 3'd1, 2'b11, 3'd1, 8'hC0);
    issue8(8'h90, 3'd2, 2'b10, 3'd2, 8'hE4);
    idle_all();
    drain("drain_w8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
